xor_diff_accumulator: RTL and testbench
=======================================

Name: xor_diff_accumulator

Overview:
- Consumes the per-bit difference vector produced by the 32-bit XOR stage, which compares golden and device-under-test outputs.
- Over a run of N captured vectors it accumulates:
  - total mismatched-bit count
  - number of failing vectors
  - index of the first failing vector
  - sticky OR mask of failing bit positions
- At end of run it raises a Trojan-suspect flag when total mismatched bits exceed a threshold.
- Sits between the XOR difference stage and the result readout/UART logic of the delay-based detection flow.

Parameters:
- WIDTH, 32, width of difference vector
- CNT_W, 16, width of vector counters and num_vectors
- THRESH, 0, Trojan flag asserted when bit_total > THRESH

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- num_vectors  input  CNT_W  run length N; sampled on accepted start
- diff_valid  input  1  diff carries a new XOR result this cycle
- diff  input  WIDTH  XOR difference vector (1 = mismatching bit)
- busy  output  1  high in RUN
- done  output  1  high in DONE, held until next start or rst
- bit_total  output  CNT_W+6  sum of popcount(diff) over accepted vectors
- fail_cnt  output  CNT_W  count of accepted vectors with diff != 0
- first_fail_idx  output  CNT_W  0-based index of first nonzero vector
- first_fail_valid  output  1  first_fail_idx holds a valid index
- fail_mask  output  WIDTH  OR of all accepted diff vectors
- trojan_flag  output  1  bit_total > THRESH; valid only while done=1

Behaviour:
- Reset: state=IDLE. All outputs 0: busy, done, bit_total, fail_cnt, first_fail_idx, first_fail_valid, fail_mask, trojan_flag. Internal vec_cnt and target also 0. rst has priority over every other input, including mid-run, and discards the partial run.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 (cycle T):
  - At T+1: accumulators, vec_cnt, first_fail_valid, done and trojan_flag cleared; target <= num_vectors.
  - num_vectors != 0 -> RUN, busy=1 from T+1.
  - num_vectors == 0 -> DONE directly at T+1 with zero results, trojan_flag = (0 > THRESH).
- RUN, diff_valid=1 (accept) at cycle T; all updates visible at T+1:
  - bit_total += popcount(diff).
  - fail_mask |= diff.
  - If diff != 0: fail_cnt += 1.
  - If diff != 0 and first_fail_valid=0: first_fail_idx <= vec_cnt, first_fail_valid <= 1.
  - vec_cnt += 1.
  - If vec_cnt+1 == target: next state DONE. At T+1: busy=0, done=1, trojan_flag = (updated bit_total > THRESH).
- RUN with diff_valid=0: no change.
- Ignored inputs: start while in RUN; diff_valid while in IDLE or DONE.
- Width rules:
  - bit_total is CNT_W+6 bits and cannot overflow (max (2^CNT_W - 1) x 32).
  - popcount is a combinational adder tree, WIDTH-generic.
- Throughput: one vector per cycle, back-to-back diff_valid allowed. Result latency from last accepted vector to done is 1 cycle.
- Results hold stable in DONE until the next accepted start or rst.

Test Plan:
- Reset: assert rst 2 cycles, with start=1 and diff_valid=1 held -> all outputs 0, busy=0, state IDLE.
- Clean run: N=4; diffs 0,0,0,0 back-to-back -> done 1 cycle after 4th; bit_total=0, fail_cnt=0, first_fail_valid=0, fail_mask=0, trojan_flag=0.
- Mixed run: N=3, diffs 0x00000000, 0x80000001, 0x0000000F, diff_valid gapped (valid 1,0,1,0,1) -> bit_total=6, fail_cnt=2, first_fail_idx=1, fail_mask=0x8000000F, trojan_flag=1 (THRESH=0).
- Zero length: N=0 start -> done=1 next cycle, busy never high, all counts 0.
- Ignored inputs: diff_valid=1 with diff=0xFFFFFFFF while IDLE, then start pulse during RUN -> no effect on counts or target.
- Abort and restart: rst asserted after 2 of 5 vectors -> outputs 0, IDLE. New run N=1, diff=0x1 -> bit_total=1, first_fail_idx=0. Restart from DONE clears previous results on the cycle after start.

Source files
------------

// File: rtl/xor_diff_accumulator.sv
// xor_diff_accumulator: accumulates XOR mismatch statistics over a run of N vectors and flags Trojan suspects
module xor_diff_accumulator #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16,
  parameter int THRESH = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vectors,
  input  logic               diff_valid,
  input  logic [WIDTH-1:0]   diff,
  output logic               busy,
  output logic               done,
  output logic [CNT_W+5:0]   bit_total,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   first_fail_idx,
  output logic               first_fail_valid,
  output logic [WIDTH-1:0]   fail_mask,
  output logic               trojan_flag
);
  localparam int BT_W = CNT_W + 6;
  localparam int PC_W = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [CNT_W-1:0] vec_cnt, target, vec_nxt;
  logic [PC_W-1:0]  pc;
  logic             nz;
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + PC_W'(diff[i]);
  end
  assign nz          = diff != '0;
  assign vec_nxt     = vec_cnt + CNT_W'(1);
  assign busy        = state == RUN;
  assign done        = state == DONE;
  assign trojan_flag = done && (bit_total > BT_W'(THRESH));
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bit_total        <= '0;
      fail_cnt         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      fail_mask        <= '0;
      vec_cnt          <= '0;
      target           <= '0;
    end else if (state != RUN && start) begin
      bit_total        <= '0;
      fail_cnt         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      fail_mask        <= '0;
      vec_cnt          <= '0;
      target           <= num_vectors;
      state            <= num_vectors != '0 ? RUN : DONE;
    end else if (state == RUN && diff_valid) begin
      bit_total <= bit_total + BT_W'(pc);
      fail_mask <= fail_mask | diff;
      fail_cnt  <= fail_cnt + CNT_W'(nz);
      if (nz && !first_fail_valid) begin
        first_fail_idx   <= vec_cnt;
        first_fail_valid <= 1'b1;
      end
      vec_cnt <= vec_nxt;
      state   <= vec_nxt == target ? DONE : RUN;
    end
  end
endmodule

// File: tb/tb_xor_diff_accumulator.sv
// tb_xor_diff_accumulator: scoreboard bench for xor_diff_accumulator
module tb_xor_diff_accumulator;
  logic        clk = 0, rst = 0, start = 0, diff_valid = 0;
  logic [15:0] num_vectors = '0;
  logic [31:0] diff = '0;
  logic        busy, done, first_fail_valid, trojan_flag;
  logic [21:0] bit_total;
  logic [15:0] fail_cnt, first_fail_idx;
  logic [31:0] fail_mask;
  int tests = 0, fails = 0;
  typedef struct {
    logic [21:0] bt;
    logic [15:0] fc, ffi;
    logic        ffv;
    logic [31:0] mask;
    logic        flag;
  } res_t;
  res_t sb[$];
  xor_diff_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .diff_valid(diff_valid), .diff(diff), .busy(busy), .done(done),
    .bit_total(bit_total), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid), .fail_mask(fail_mask), .trojan_flag(trojan_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_total"}, bit_total, 0);
    chk({tag, "_fcnt"}, fail_cnt, 0);
    chk({tag, "_ffi"}, first_fail_idx, 0);
    chk({tag, "_ffv"}, first_fail_valid, 0);
    chk({tag, "_mask"}, fail_mask, 0);
    chk({tag, "_flag"}, trojan_flag, 0);
  endtask
  task automatic run(input string tag, input logic [15:0] n, input logic [31:0] d[$], input bit gap, input bit poke);
    res_t e;
    res_t r;
    e = '{bt: 0, fc: 0, ffi: 0, ffv: 0, mask: 0, flag: 0};
    for (int i = 0; i < int'(n); i++) begin
      e.bt += 22'($countones(d[i]));
      e.mask |= d[i];
      if (d[i] != 0) begin
        if (!e.ffv) begin
          e.ffi = 16'(i);
          e.ffv = 1;
        end
        e.fc++;
      end
    end
    e.flag = e.bt > 0;
    sb.push_back(e);
    @(negedge clk);
    start = 1;
    num_vectors = n;
    @(negedge clk);
    start = 0;
    num_vectors = $urandom;
    chk({tag, "_busy_start"}, busy, n != 0);
    chk({tag, "_done_start"}, done, n == 0);
    chk({tag, "_clr_total"}, bit_total, 0);
    chk({tag, "_clr_fcnt"}, fail_cnt, 0);
    chk({tag, "_clr_ffv"}, first_fail_valid, 0);
    for (int i = 0; i < int'(n); i++) begin
      diff_valid = 1;
      diff = d[i];
      if (poke && i == 0) begin
        start = 1;
        num_vectors = 16'd7;
      end
      @(negedge clk);
      diff_valid = 0;
      start = 0;
      diff = $urandom;
      if (gap && i < int'(n) - 1) begin
        chk({tag, "_busy_gap"}, busy, 1);
        @(negedge clk);
      end
    end
    chk({tag, "_latency_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    r = sb.pop_front();
    chk({tag, "_total"}, bit_total, r.bt);
    chk({tag, "_fcnt"}, fail_cnt, r.fc);
    chk({tag, "_ffv"}, first_fail_valid, r.ffv);
    if (r.ffv) chk({tag, "_ffi"}, first_fail_idx, r.ffi);
    chk({tag, "_mask"}, fail_mask, r.mask);
    chk({tag, "_flag"}, trojan_flag, r.flag);
    @(negedge clk);
    chk({tag, "_hold_done"}, done, 1);
    chk({tag, "_hold_total"}, bit_total, r.bt);
  endtask
  initial begin
    logic [31:0] q[$];
    @(negedge clk);
    rst = 1; start = 1; diff_valid = 1; diff = 32'hFFFF_FFFF; num_vectors = 16'd3;
    repeat (2) @(negedge clk);
    rst = 0; start = 0; diff_valid = 0;
    chk_zero("reset");
    diff_valid = 1;
    repeat (2) @(negedge clk);
    diff_valid = 0;
    chk_zero("idle_ignore");
    q = {32'h0, 32'h0, 32'h0, 32'h0};
    run("clean", 16'd4, q, 0, 0);
    q = {32'h0, 32'h8000_0001, 32'h0000_000F};
    run("mixed", 16'd3, q, 1, 0);
    q = {};
    run("zero", 16'd0, q, 0, 0);
    q = {32'h0000_00F0, 32'h0000_0100};
    run("poke", 16'd2, q, 0, 1);
    @(negedge clk);
    start = 1; num_vectors = 16'd5;
    @(negedge clk);
    start = 0;
    repeat (2) begin
      diff_valid = 1; diff = 32'h0000_0003;
      @(negedge clk);
    end
    diff_valid = 0;
    chk("abort_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_zero("abort");
    q = {32'h1};
    run("one", 16'd1, q, 0, 0);
    q = {32'hFFFF_FFFF, 32'h0, 32'h0000_0010, 32'hA5A5_0000, 32'h0};
    run("rand", 16'd5, q, 1, 0);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
